// File: rtl/frog_hopper.sv
// frog_hopper: frame-rate frog movement controller.
// One grid hop per key press, animated over HOP_FRAMES frames, with per-axis
// playfield bounds, river-platform drift with side clamping, and respawn.
// Optional feature macro: FROG_AUTOREPEAT_EN (held facing key re-hops every
// REPEAT_FRAMES frames while in WAIT).
module frog_hopper #(
  parameter int COORD_W       = 11,
  parameter int STEP_X        = 40,
  parameter int STEP_Y        = 40,
  parameter int HOP_FRAMES    = 4,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 640,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 480,
  parameter int START_X       = 320,
  parameter int START_Y       = 440,
  parameter int FROG_W        = 40,
  parameter int FROG_H        = 40,
  parameter int CARRY_W       = 4,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               respawn,
  input  logic               carry_en,
  input  logic [CARRY_W-1:0] carry_dx,
  output logic [COORD_W-1:0] FrogX,
  output logic [COORD_W-1:0] FrogY,
  output logic [COORD_W-1:0] Frog_Width,
  output logic [COORD_W-1:0] Frog_Height,
  output logic               hopping,
  output logic [1:0]         facing,
  output logic               hop_done,
  output logic               blocked,
  output logic               edge_hit
);

  // One extra bit so that a hop past the low edge shows up as negative.
  localparam int SW    = COORD_W + 1;
  localparam int CNT_W = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;

  localparam logic signed [SW-1:0] STEP_X_S = SW'(STEP_X);
  localparam logic signed [SW-1:0] STEP_Y_S = SW'(STEP_Y);
  localparam logic signed [SW-1:0] X_MIN_S  = SW'(X_MIN);
  localparam logic signed [SW-1:0] X_MAX_S  = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MIN_S  = SW'(Y_MIN);
  localparam logic signed [SW-1:0] Y_MAX_S  = SW'(Y_MAX);
  localparam logic signed [SW-1:0] FROG_W_S = SW'(FROG_W);
  localparam logic signed [SW-1:0] FROG_H_S = SW'(FROG_H);
  localparam logic signed [SW-1:0] X_LIM_S  = SW'(X_MAX - FROG_W);
  localparam logic [COORD_W-1:0]   DSTEP_X  = COORD_W'(STEP_X / HOP_FRAMES);
  localparam logic [COORD_W-1:0]   DSTEP_Y  = COORD_W'(STEP_Y / HOP_FRAMES);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(HOP_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, HOP, WAIT} state_t;

  state_t             state_reg, state_next;
  logic [COORD_W-1:0] x_reg, x_next, y_reg, y_next;
  logic [COORD_W-1:0] tx_reg, tx_next, ty_reg, ty_next;
  logic [CNT_W-1:0]   hop_cnt_reg, hop_cnt_next;
  logic [1:0]         facing_reg, facing_next;
  logic               hop_done_reg, hop_done_next;
  logic               blocked_reg, blocked_next;
  logic               edge_hit_reg, edge_hit_next;
`ifdef FROG_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  logic [RPT_W-1:0]   rpt_cnt_reg, rpt_cnt_next;
`endif

  logic [3:0]          keys;       // indexed by facing code: up, down, left, right
  logic                key_any;
  logic [1:0]          key_dir;
  logic [1:0]          eval_dir;
  logic signed [SW-1:0] tx, ty, nx, dx_ext;
  logic                legal;
  logic                apply_drift;

  assign keys    = {right, left, down, up};
  assign key_any = |keys;

  // Key priority down > up > left > right; WAIT re-evaluates the facing direction.
  always_comb begin
    key_dir = 2'd3;
    if (down)      key_dir = 2'd1;
    else if (up)   key_dir = 2'd0;
    else if (left) key_dir = 2'd2;
    eval_dir = (state_reg == WAIT) ? facing_reg : key_dir;
  end

  // Candidate hop target and its legality, in signed arithmetic to catch underflow.
  always_comb begin
    tx = signed'({1'b0, x_reg});
    ty = signed'({1'b0, y_reg});
    case (eval_dir)
      2'd0:    ty = ty - STEP_Y_S;
      2'd1:    ty = ty + STEP_Y_S;
      2'd2:    tx = tx - STEP_X_S;
      default: tx = tx + STEP_X_S;
    endcase
    legal = (tx >= X_MIN_S) && (tx + FROG_W_S <= X_MAX_S) &&
            (ty >= Y_MIN_S) && (ty + FROG_H_S <= Y_MAX_S);
  end

  // Drift candidate position: sign-extended carry added to X.
  always_comb begin
    dx_ext = {{(SW - CARRY_W){carry_dx[CARRY_W-1]}}, carry_dx};
    nx     = signed'({1'b0, x_reg}) + dx_ext;
  end

  // Next-state, position and pulse logic.
  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    tx_next       = tx_reg;
    ty_next       = ty_reg;
    hop_cnt_next  = hop_cnt_reg;
    facing_next   = facing_reg;
    hop_done_next = 1'b0;
    blocked_next  = 1'b0;
    edge_hit_next = 1'b0;
    apply_drift   = 1'b0;
`ifdef FROG_AUTOREPEAT_EN
    rpt_cnt_next  = rpt_cnt_reg;
`endif
    if (respawn) begin
      x_next     = COORD_W'(START_X);
      y_next     = COORD_W'(START_Y);
      state_next = WAIT;
`ifdef FROG_AUTOREPEAT_EN
      rpt_cnt_next = '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          apply_drift = 1'b1;
          if (key_any) begin
            facing_next = key_dir;
            if (legal) begin
              tx_next      = tx[COORD_W-1:0];
              ty_next      = ty[COORD_W-1:0];
              hop_cnt_next = '0;
              state_next   = HOP;
              apply_drift  = 1'b0;
            end else begin
              blocked_next = 1'b1;
              state_next   = WAIT;
            end
`ifdef FROG_AUTOREPEAT_EN
            rpt_cnt_next = '0;
`endif
          end
        end
        HOP: begin
          if (hop_cnt_reg == LAST_CNT) begin
            x_next        = tx_reg;
            y_next        = ty_reg;
            hop_done_next = 1'b1;
            state_next    = WAIT;
`ifdef FROG_AUTOREPEAT_EN
            rpt_cnt_next  = '0;
`endif
          end else begin
            hop_cnt_next = hop_cnt_reg + 1'b1;
            case (facing_reg)
              2'd0:    y_next = y_reg - DSTEP_Y;
              2'd1:    y_next = y_reg + DSTEP_Y;
              2'd2:    x_next = x_reg - DSTEP_X;
              default: x_next = x_reg + DSTEP_X;
            endcase
          end
        end
        WAIT: begin
          apply_drift = 1'b1;
          if (!key_any) begin
            state_next = IDLE;
          end
`ifdef FROG_AUTOREPEAT_EN
          else if (keys[facing_reg]) begin
            if (rpt_cnt_reg == RPT_W'(REPEAT_FRAMES - 1)) begin
              rpt_cnt_next = '0;
              if (legal) begin
                tx_next      = tx[COORD_W-1:0];
                ty_next      = ty[COORD_W-1:0];
                hop_cnt_next = '0;
                state_next   = HOP;
                apply_drift  = 1'b0;
              end else begin
                blocked_next = 1'b1;
              end
            end else begin
              rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
          end
`endif
        end
        default: state_next = IDLE;
      endcase
      if (apply_drift && carry_en) begin
        if (nx < X_MIN_S) begin
          x_next        = COORD_W'(X_MIN);
          edge_hit_next = 1'b1;
        end else if (nx > X_LIM_S) begin
          x_next        = COORD_W'(X_MAX - FROG_W);
          edge_hit_next = 1'b1;
        end else begin
          x_next = nx[COORD_W-1:0];
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      x_reg        <= COORD_W'(START_X);
      y_reg        <= COORD_W'(START_Y);
      tx_reg       <= '0;
      ty_reg       <= '0;
      hop_cnt_reg  <= '0;
      facing_reg   <= 2'd0;
      hop_done_reg <= 1'b0;
      blocked_reg  <= 1'b0;
      edge_hit_reg <= 1'b0;
`ifdef FROG_AUTOREPEAT_EN
      rpt_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      tx_reg       <= tx_next;
      ty_reg       <= ty_next;
      hop_cnt_reg  <= hop_cnt_next;
      facing_reg   <= facing_next;
      hop_done_reg <= hop_done_next;
      blocked_reg  <= blocked_next;
      edge_hit_reg <= edge_hit_next;
`ifdef FROG_AUTOREPEAT_EN
      rpt_cnt_reg  <= rpt_cnt_next;
`endif
    end
  end

  assign FrogX       = x_reg;
  assign FrogY       = y_reg;
  assign Frog_Width  = COORD_W'(FROG_W);
  assign Frog_Height = COORD_W'(FROG_H);
  assign hopping     = (state_reg == HOP);
  assign facing      = facing_reg;
  assign hop_done    = hop_done_reg;
  assign blocked     = blocked_reg;
  assign edge_hit    = edge_hit_reg;

endmodule

// File: doc/frog_hopper.md
# frog_hopper

Parametrised player-movement controller, successor to the single-step frog mover. It converts debounced direction keys into one grid hop per press and animates each hop over several frames. It enforces playfield bounds per axis, applies river-platform drift, and supports respawn. It sits between the keyboard decode and the sprite/collision logic, clocked once per video frame.

## Interface
- COORD_W, 11, coordinate width (unsigned pixels)
- STEP_X, 40, horizontal hop distance
- STEP_Y, 40, vertical hop distance
- HOP_FRAMES, 4, frames per hop animation; STEP_X and STEP_Y must be divisible by it; minimum 1
- X_MIN / X_MAX, 0 / 640, horizontal playfield limits (frog occupies X..X+FROG_W-1)
- Y_MIN / Y_MAX, 0 / 480, vertical playfield limits
- START_X / START_Y, 320 / 440, reset and respawn position
- FROG_W / FROG_H, 40 / 40, sprite size
- CARRY_W, 4, width of signed drift input
- REPEAT_FRAMES, 8, auto-repeat period (used only with FROG_AUTOREPEAT_EN)

Ports:
- frame_clk  in  1  frame-rate clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- up, down, left, right  in  1 each  direction keys, level
- respawn  in  1  single-cycle request to return to start
- carry_en  in  1  frog is on a moving platform this frame
- carry_dx  in  CARRY_W  signed two's-complement drift, pixels/frame
- FrogX, FrogY  out  COORD_W  current top-left position
- Frog_Width, Frog_Height  out  COORD_W  constants FROG_W, FROG_H
- hopping  out  1  high while in HOP
- facing  out  2  last accepted direction: 0 up, 1 down, 2 left, 3 right
- hop_done  out  1  one-cycle pulse on the edge the frog lands
- blocked  out  1  one-cycle pulse when a requested hop is rejected
- edge_hit  out  1  one-cycle pulse when drift is clamped at a side

## Operation
- States: IDLE, HOP, WAIT.
- Reset: FrogX=START_X, FrogY=START_Y, state IDLE, facing=0, all pulses 0.
- IDLE: key priority is down > up > left > right. The target is current position ± STEP on that axis.
  - Target is legal when X_MIN ≤ tx, tx+FROG_W ≤ X_MAX, Y_MIN ≤ ty, and ty+FROG_H ≤ Y_MAX, with all arithmetic evaluated at COORD_W+1 bits signed so that underflow is detected.
  - Legal target: latch it, set facing, go to HOP.
  - Illegal target: pulse blocked, set facing, go to WAIT, no movement.
- HOP: each edge moves the position by ±STEP/HOP_FRAMES on the hop axis.
  - On the HOP_FRAMES-th HOP edge, the position is forced to the latched target (snap).
  - On that same edge: pulse hop_done, go to WAIT.
  - Keys are ignored in HOP.
- WAIT: go to IDLE on the edge where all four keys are low. Holding a key never produces a second hop.
- Drift: applies on every edge in IDLE or WAIT while carry_en=1, and never in HOP.
  - FrogX += sign-extended carry_dx.
  - Result is clamped to [X_MIN, X_MAX−FROG_W]; any clamp pulses edge_hit.
- respawn: highest priority after Reset. Next edge: position = START, state WAIT, pulses 0. Works in any state, including mid-hop.
- If respawn and a key are both asserted on the same edge, respawn wins.

## Timing
- A key is sampled at edge k in IDLE. The position changes on edges k+1 through k+HOP_FRAMES, and the frog arrives at edge k+HOP_FRAMES with hop_done high for that cycle.
- HOP_FRAMES=1: a single-edge hop, moving directly to the target.
- The minimum interval between hop starts is HOP_FRAMES+2 edges: HOP, at least one WAIT edge, then at least one IDLE edge.
- blocked, edge_hit and hop_done are registered, high for exactly one cycle.
- A Reset asserted mid-hop wins on that edge; the latched target is discarded.

## Configuration
- FROG_AUTOREPEAT_EN defined: WAIT has a repeat counter, cleared on entering WAIT.
  - The counter increments each edge while the facing key is held.
  - When the counter reaches REPEAT_FRAMES−1 with the key still held, the same-direction hop is evaluated as in IDLE: legal goes to HOP, illegal pulses blocked and clears the counter.
  - Releasing all keys returns to IDLE as usual.
- FROG_AUTOREPEAT_EN undefined: there is no counter and exactly one hop per press; REPEAT_FRAMES is unused.

## Test plan
- Reset, then up high for 1 frame → FrogY 430, 420, 410, 400 on successive edges; hop_done with FrogY=400; facing=0.
- From reset (Y=440), press down → blocked pulse, FrogY stays 440, state WAIT until release.
- Hold right for 20 frames, macro off → exactly one hop, FrogX 320→360, then static until release.
- FrogX=2, carry_en=1, carry_dx=−3 → FrogX=0, edge_hit pulse; carry_dx=+5 at FrogX=598 → FrogX=600, edge_hit.
- respawn on the 2nd HOP edge of an up hop → next edge FrogX=320, FrogY=440, hopping=0, no hop_done; a held key does not start a hop until released.
- Macro on, REPEAT_FRAMES=8, hold left from X=320 → landings at 280, 240, 200, each next hop starting 8 edges after the previous landing; the hop from X=0 is blocked.
